// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: applies the FIPS-197 inverse S-box to a 128-bit
// state, BYTES_PER_CYCLE bytes per clock, with ready/valid on both sides.
module inv_sub_bytes_seq #(
   parameter int unsigned BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] prevState,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] nextState
);

   localparam int unsigned N       = 16 / BYTES_PER_CYCLE;
   localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CHUNK_W = 8 * BYTES_PER_CYCLE;
   localparam logic [127:0] LOW_MASK = {128{1'b1}} >> (128 - CHUNK_W);

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
         BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bpc_check
      $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [127:0]         w_q, w_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [6:0]           lsb;
   logic [CHUNK_W-1:0]   chunk_in;
   logic [CHUNK_W-1:0]   chunk_out;
   logic                 last_chunk;

   // Chunk 0 is the most significant; lsb is the bit offset of the current chunk.
   assign lsb        = 7'(CNT_W'(N - 1) - cnt_q) * 7'(CHUNK_W);
   assign chunk_in   = CHUNK_W'(w_q >> lsb);
   assign last_chunk = (cnt_q == CNT_W'(N - 1));

   for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_sbox
      assign chunk_out[CHUNK_W-1-8*i -: 8] = INV_SBOX[chunk_in[CHUNK_W-1-8*i -: 8]];
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)   state_d = BUSY;
         BUSY:    if (last_chunk) state_d = DONE;
         DONE:    if (out_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register only
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Working register and chunk counter
   always_comb begin
      w_d   = w_q;
      cnt_d = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               w_d   = prevState;
               cnt_d = '0;
            end
         end
         BUSY: begin
            w_d = (w_q & ~(LOW_MASK << lsb)) | (128'(chunk_out) << lsb);
            if (!last_chunk) cnt_d = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_q   <= '0;
         cnt_q <= '0;
      end else begin
         w_q   <= w_d;
         cnt_q <= cnt_d;
      end
   end

   assign nextState = w_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq; reference S-box derived from GF(2^8)
// arithmetic, plus one-shot checks of every other legal BYTES_PER_CYCLE.
module tb_inv_sub_bytes_seq;

   localparam int unsigned BPC    = 4;
   localparam int unsigned N      = 16 / BPC;
   localparam logic [127:0] VEC_IN  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] VEC_OUT = 128'h52096ad53036a538bf40a39e81f3d7fb;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         reset_alt = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] prevState = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] nextState;

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;
   int cyc     = 0;
   logic [127:0] sb_q[$];
   logic [7:0]   fwd_tbl [256];
   logic [7:0]   inv_tbl [256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .prevState(prevState), .out_valid(out_valid), .out_ready(out_ready),
      .nextState(nextState)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [127:0] apply_inv(input logic [127:0] x);
      logic [127:0] y;
      for (int i = 0; i < 16; i++) y[8*i +: 8] = inv_tbl[x[8*i +: 8]];
      return y;
   endfunction

   function automatic logic [127:0] apply_fwd(input logic [127:0] x);
      logic [127:0] y;
      for (int i = 0; i < 16; i++) y[8*i +: 8] = fwd_tbl[x[8*i +: 8]];
      return y;
   endfunction

   task automatic build_tables();
      logic [7:0] r, s;
      for (int a = 0; a < 256; a++) begin
         r = 8'h01;
         for (int k = 0; k < 254; k++) r = gmul(r, 8'(a));
         s = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
         fwd_tbl[a] = s;
         inv_tbl[s] = 8'(a);
      end
   endtask

   // Output side of the scoreboard: a result is consumed on the next rising edge
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
         if (sb_q.size() != 0) check("sb_data", nextState, sb_q.pop_front());
         n_out++;
      end
   end

   task automatic send(input logic [127:0] s, input logic [127:0] e, input bit push);
      int guard = 0;
      while (!in_ready && guard < 64) begin
         @(posedge clk); #1;
         guard++;
      end
      check("send_ready", 128'(in_ready), 128'(1));
      in_valid  = 1'b1;
      prevState = s;
      if (push) sb_q.push_back(e);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      prevState = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic stream(input int count, input bit roundtrip);
      logic [127:0] x, s, e;
      int last_acc = 0;
      int guard;
      int out0 = n_out;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < count; i++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         if (roundtrip) begin s = apply_fwd(x); e = x; end
         else           begin s = x; e = apply_inv(x); end
         prevState = s;
         guard = 0;
         while (!in_ready && guard < 64) begin
            @(posedge clk); #1;
            guard++;
         end
         if (!in_ready) begin
            check("stream_timeout", 128'(in_ready), 128'(1));
            break;
         end
         sb_q.push_back(e);
         @(posedge clk); #1;
         if (i > 0) check(roundtrip ? "rt_interval" : "stream_interval",
                          128'(cyc - last_acc), 128'(N + 2));
         last_acc = cyc;
      end
      in_valid = 1'b0;
      guard = 0;
      while (sb_q.size() != 0 && guard < 64) begin
         @(posedge clk); #1;
         guard++;
      end
      check(roundtrip ? "rt_drained" : "stream_drained", 128'(sb_q.size()), 128'(0));
      check(roundtrip ? "rt_count" : "stream_count", 128'(n_out - out0), 128'(count));
   endtask

   // Other legal widths: one known vector each, latency 16/B
   for (genvar g = 0; g < 4; g++) begin : g_alt
      localparam int unsigned B  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      localparam int unsigned NB = 16 / B;
      logic         a_in_valid = 1'b0;
      logic         a_in_ready;
      logic         a_out_valid;
      logic [127:0] a_state = '0;
      logic [127:0] a_next;
      logic         done = 1'b0;

      inv_sub_bytes_seq #(.BYTES_PER_CYCLE(B)) u_dut (
         .clk(clk), .reset(reset_alt), .in_valid(a_in_valid), .in_ready(a_in_ready),
         .prevState(a_state), .out_valid(a_out_valid), .out_ready(1'b1),
         .nextState(a_next)
      );

      initial begin : p_alt
         int lat;
         repeat (5) @(posedge clk);
         #1;
         check($sformatf("bpc%0d_ready", B), 128'(a_in_ready), 128'(1));
         a_in_valid = 1'b1;
         a_state    = VEC_IN;
         @(posedge clk); #1;
         a_in_valid = 1'b0;
         a_state    = '1;
         lat = 0;
         while (!a_out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
         end
         check($sformatf("bpc%0d_latency", B), 128'(lat), 128'(NB));
         check($sformatf("bpc%0d_data", B), a_next, VEC_OUT);
         done = 1'b1;
      end
   end

   initial begin : p_main
      int lat;
      logic [127:0] v, e;
      logic bad;
      build_tables();

      #1;
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_next", nextState, 128'h0);
      repeat (3) @(posedge clk);
      #1;
      reset     = 1'b0;
      reset_alt = 1'b0;
      out_ready = 1'b1;

      // Directed vectors
      send(128'h0, {16{8'h52}}, 1'b1);
      wait_valid(lat);
      check("zero_latency", 128'(lat), 128'(N));
      check("zero_data", nextState, {16{8'h52}});
      @(posedge clk); #1;
      send({16{8'h63}}, 128'h0, 1'b1);
      wait_valid(lat);
      check("x63_data", nextState, 128'h0);
      @(posedge clk); #1;
      send(VEC_IN, VEC_OUT, 1'b1);
      wait_valid(lat);
      check("vec_latency", 128'(lat), 128'(N));
      @(posedge clk); #1;

      // Backpressure with a competing in_valid
      out_ready = 1'b0;
      v = {$urandom, $urandom, $urandom, $urandom};
      e = apply_inv(v);
      send(v, e, 1'b1);
      wait_valid(lat);
      check("bp_latency", 128'(lat), 128'(N));
      for (int i = 0; i < 10; i++) begin
         in_valid  = 1'b1;
         prevState = ~v;
         @(posedge clk); #1;
         check("bp_out_valid", 128'(out_valid), 128'(1));
         check("bp_hold", nextState, e);
         check("bp_in_ready", 128'(in_ready), 128'(0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("bp_release_ready", 128'(in_ready), 128'(1));
      check("bp_release_valid", 128'(out_valid), 128'(0));
      bad = 1'b0;
      repeat (N + 3) begin
         @(posedge clk); #1;
         if (out_valid || !in_ready) bad = 1'b1;
      end
      check("bp_no_stray_accept", 128'(bad), 128'(0));

      // Reset in the middle of BUSY
      out_ready = 1'b1;
      send(v, e, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("rstbusy_in_ready", 128'(in_ready), 128'(1));
      check("rstbusy_out_valid", 128'(out_valid), 128'(0));
      check("rstbusy_next", nextState, 128'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      bad = 1'b0;
      repeat (N + 4) begin
         @(posedge clk); #1;
         if (out_valid) bad = 1'b1;
      end
      check("rstbusy_never_valid", 128'(bad), 128'(0));

      // Reset while holding a finished result
      out_ready = 1'b0;
      send(v, e, 1'b0);
      wait_valid(lat);
      check("rstdone_reached", 128'(out_valid), 128'(1));
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("rstdone_out_valid", 128'(out_valid), 128'(0));
      check("rstdone_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;

      // Reset release together with in_valid: accept on first clean edge
      v = {$urandom, $urandom, $urandom, $urandom};
      reset     = 1'b0;
      in_valid  = 1'b1;
      prevState = v;
      out_ready = 1'b1;
      sb_q.push_back(apply_inv(v));
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      check("rstrel_latency", 128'(lat), 128'(N));
      @(posedge clk); #1;
      check("rstrel_drained", 128'(sb_q.size()), 128'(0));

      stream(100, 1'b0);
      stream(1000, 1'b1);

      check("alt1_done", 128'(g_alt[0].done), 128'(1));
      check("alt2_done", 128'(g_alt[1].done), 128'(1));
      check("alt8_done", 128'(g_alt[2].done), 128'(1));
      check("alt16_done", 128'(g_alt[3].done), 128'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
